// File: rtl/rw_sched_pkg.sv
// Shared types and helpers for the resumption scheduler.
// State enum, default reset tag, index-to-onehot helper.
package rw_sched_pkg;

  typedef enum logic {
    IDLE,
    EVAL
  } state_t;

  localparam logic [63:0] TAG_RESET_ALL = '1;

  function automatic logic [63:0] idx_onehot(
    input int unsigned idx
  );
    return 64'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, searching upward from ptr.
// Ports: req/ptr in; gnt (onehot), gnt_idx, any out.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/resumption_scheduler.sv
// Shares one combinational step device among N_REQ requesters.
// Ports: req_*/ctx_clear in, req_ready/rsp_*/done out, dev_* link.
module resumption_scheduler
  import rw_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 1,
  parameter int IN_W  = 1,
  parameter int OUT_W = 1,
  parameter logic [TAG_W-1:0] TAG_RESET =
    TAG_W'(TAG_RESET_ALL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*IN_W-1:0] req_in,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      ctx_clear,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [OUT_W-1:0]      rsp_out,
  output logic [N_REQ-1:0]      done,
  output logic [TAG_W-1:0]      dev_tag,
  output logic [IN_W-1:0]       dev_in,
  input  logic                  dev_continue,
  input  logic [OUT_W-1:0]      dev_out,
  input  logic [TAG_W-1:0]      dev_tag_next
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   lat_idx;
  logic [IN_W-1:0] lat_in;
  logic [TAG_W-1:0] lat_tag;
  logic [TAG_W-1:0] tag_ctx [N_REQ];
  logic [IN_W-1:0] in_arr  [N_REQ];

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             any;
  logic             accept;

  for (genvar i = 0; i < N_REQ; i++) begin : g_in
    assign in_arr[i] = req_in[i*IN_W +: IN_W];
  end

  assign elig = req_valid & ~done;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Grant is gated by rst so nothing looks ready during reset.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst && any) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_nx  = EVAL;
        end
      end
      EVAL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_idx   <= '0;
      lat_in    <= '0;
      lat_tag   <= TAG_RESET;
      rsp_valid <= '0;
      rsp_out   <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= '0;
      if (accept) begin
        lat_idx <= gnt_idx;
        lat_in  <= in_arr[gnt_idx];
        lat_tag <= tag_ctx[gnt_idx];
        rr_ptr  <= (gnt_idx == IW'(N_REQ-1)) ?
                   '0 : gnt_idx + 1'b1;
      end
      if (state == EVAL) begin
        rsp_valid <= N_REQ'(idx_onehot(32'(lat_idx)));
        rsp_out   <= dev_out;
      end
    end
  end

  // A clear beats a same-cycle writeback to the same context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        tag_ctx[i] <= TAG_RESET;
      end
      done <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ctx_clear[i]) begin
          tag_ctx[i] <= TAG_RESET;
          done[i]    <= 1'b0;
        end else if (state == EVAL &&
                     lat_idx == IW'(i)) begin
          tag_ctx[i] <= dev_tag_next;
          done[i]    <= ~dev_continue;
        end
      end
    end
  end

  assign dev_tag = lat_tag;
  assign dev_in  = lat_in;

endmodule

// File: tb/tb_resumption_scheduler.sv
// Scoreboard bench for resumption_scheduler with a toggle device.
// Stimulus pushes expected responses; a monitor pops and compares.
module tb_resumption_scheduler;

  typedef struct {
    int   idx;
    logic out;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_in;
  logic [3:0] req_ready;
  logic [3:0] ctx_clear;
  logic [3:0] rsp_valid;
  logic [0:0] rsp_out;
  logic [3:0] done;
  logic [0:0] dev_tag;
  logic [0:0] dev_in;
  logic       dev_continue;
  logic [0:0] dev_out;
  logic [0:0] dev_tag_next;
  logic       halt;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  resumption_scheduler #(
    .N_REQ(4), .TAG_W(1), .IN_W(1), .OUT_W(1),
    .TAG_RESET(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_in       (req_in),
    .req_ready    (req_ready),
    .ctx_clear    (ctx_clear),
    .rsp_valid    (rsp_valid),
    .rsp_out      (rsp_out),
    .done         (done),
    .dev_tag      (dev_tag),
    .dev_in       (dev_in),
    .dev_continue (dev_continue),
    .dev_out      (dev_out),
    .dev_tag_next (dev_tag_next)
  );

  // Toggle device: out = ~tag, next = ~tag, continue unless halted.
  assign dev_out      = ~dev_tag;
  assign dev_tag_next = ~dev_tag;
  assign dev_continue = ~halt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== 4'b0000) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: got valid=%b out=%b",
                 rsp_valid, rsp_out);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid),
            32'(4'b0001 << e.idx));
        chk("rsp_out", 32'(rsp_out), 32'(e.out));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    ctx_clear = '0;
    halt      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_grant(int i, output bit got);
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic step(int i, logic din, logic exp);
    bit   got;
    exp_t e;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_in[i]    = din;
    wait_grant(i, got);
    if (got) begin
      e.idx = i;
      e.out = exp;
      e.cyc = cyc + 2;
      sb.push_back(e);
      @(negedge clk);
      chk("dev_in", 32'(dev_in), 32'(din));
    end
    req_valid[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit   got;
    bit   seen;
    int   k;
    int   last;
    int   seq  [5] = '{0, 1, 2, 3, 0};
    logic outs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;

    rst       = 1'b0;
    req_in    = '0;
    ctx_clear = '0;
    halt      = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_out",   32'(rsp_out), 0);
    chk("rst_dev_tag",   32'(dev_tag), 1);
    chk("rst_dev_in",    32'(dev_in), 0);
    chk("rst_done",      32'(done), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // single requester, three steps
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0);

    // all four continuously valid
    do_reset();
    req_valid = 4'hF;
    k    = 0;
    last = 0;
    for (int w = 0; w < 30; w++) begin
      #1;
      if (k == 5) begin
        req_valid = '0;
        break;
      end
      if (req_ready != 4'b0000) begin
        chk("rr_grant", 32'(req_ready),
            32'(4'b0001 << seq[k]));
        if (k > 0) chk("rr_spacing", cyc - last, 2);
        last  = cyc;
        e.idx = seq[k];
        e.out = outs[k];
        e.cyc = cyc + 2;
        sb.push_back(e);
        k++;
      end
      @(negedge clk);
    end
    chk("rr_count", k, 5);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // context isolation
    do_reset();
    step(1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1);
    step(2, 1'b1, 1'b0);

    // halt and clear on requester 3
    do_reset();
    halt = 1'b1;
    step(3, 1'b0, 1'b0);
    halt = 1'b0;
    chk("halt_done", 32'(done[3]), 1);
    req_valid[3] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'b0000) seen = 1'b1;
    end
    chk("halt_no_grant", 32'(seen), 0);
    req_valid[3] = 1'b0;
    @(negedge clk);
    ctx_clear[3] = 1'b1;
    @(negedge clk);
    ctx_clear[3] = 1'b0;
    chk("clear_done", 32'(done[3]), 0);
    step(3, 1'b1, 1'b0);

    // clear collides with writeback on requester 0
    do_reset();
    @(negedge clk);
    req_valid[0] = 1'b1;
    wait_grant(0, got);
    if (got) begin
      e.idx = 0;
      e.out = 1'b0;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    ctx_clear[0] = 1'b1;
    @(negedge clk);
    ctx_clear[0] = 1'b0;
    chk("collide_done", 32'(done[0]), 0);
    step(0, 1'b0, 1'b0);

    // reset during EVAL discards the step
    do_reset();
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1);
    step(2, 1'b0, 1'b0);
    @(negedge clk);
    req_valid[3] = 1'b1;
    req_in[3]    = 1'b1;
    wait_grant(3, got);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_req_ready", 32'(req_ready), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rsp_out",   32'(rsp_out), 0);
    chk("mid_dev_tag",   32'(dev_tag), 1);
    chk("mid_dev_in",    32'(dev_in), 0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    step(0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
